// File: rtl/wide_add_seq.sv
// Multi-precision add/subtract: W = 16*NCHUNK operands pushed through one 16-bit prefix adder, LSB slice first.
// Latency NCHUNK cycles accept->out_valid; in_ready low while busy, result held until out_ready.

// 16-bit Kogge-Stone carry-prefix adder with carry-in.
// Purely combinational, zero latency; no flow control.
module adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    always_comb begin
        logic [15:0] g;
        logic [15:0] p;
        logic [15:0] gn;
        logic [15:0] pn;
        p = a ^ b;
        g = a & b;
        // Fold the carry-in into bit 0 so g[i] ends up as the carry out of bit i.
        g[0] = g[0] | (p[0] & cin);
        for (int l = 0; l < 4; l++) begin
            gn = g | (p & (g << (1 << l)));
            pn = p & ((p << (1 << l)) | ((16'd1 << (1 << l)) - 16'd1));
            g  = gn;
            p  = pn;
        end
        sum  = (a ^ b) ^ {g[14:0], cin};
        cout = g[15];
    end
endmodule

// Sequencer: captures operands, chains the carry through a register across NCHUNK adder passes.
// Latency: out_valid first high NCHUNK edges after the accept edge; accepts spaced >= NCHUNK+2 cycles.
// Backpressure: in_ready only in IDLE; DONE holds sum/cout stable until out_ready.
module wide_add_seq #(
    parameter int NCHUNK = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [16*NCHUNK-1:0] a,
    input  logic [16*NCHUNK-1:0] b,
    input  logic                cin,
    input  logic                op_sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*NCHUNK-1:0] sum,
    output logic                cout
);
    localparam int W  = 16 * NCHUNK;
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            carry;
    logic [IW-1:0]   idx;
    logic [15:0]     a_sl;
    logic [15:0]     b_sl;
    logic [15:0]     add_sum;
    logic            add_cout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)     state_nxt = RUN;
            RUN:     if (idx == LAST)  state_nxt = DONE;
            DONE:    if (out_ready)    state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx == IW'(k)) begin
                a_sl = a_reg[16*k +: 16];
                b_sl = b_reg[16*k +: 16];
            end
        end
    end

    adder u_adder (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
                        b_reg <= op_sub ? ~b : b;
                        carry <= op_sub ? 1'b1 : cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    for (int k = 0; k < NCHUNK; k++) begin
                        if (idx == IW'(k)) sum[16*k +: 16] <= add_sum;
                    end
                    carry <= add_cout;
                    if (idx == LAST) begin
                        cout <= add_cout;
                        idx  <= '0;
                    end else begin
                        idx  <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_wide_add_seq.sv
// Scoreboard bench for wide_add_seq at NCHUNK=4 and NCHUNK=1: driver pushes expected results, monitors pop on handshake.
module tb_wide_add_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        in_valid, in_ready, cin, op_sub, out_valid, out_ready, cout;
    logic [63:0] a, b, sum;
    logic        in_valid1, in_ready1, cin1, op_sub1, out_valid1, out_ready1, cout1;
    logic [15:0] a1, b1, sum1;

    int checks = 0;
    int errors = 0;
    logic [64:0] exp_q[$];
    logic [16:0] exp_q1[$];
    logic [64:0] e4;
    logic [16:0] e1;
    bit rnd_on = 1'b0;
    int lat;

    wide_add_seq #(.NCHUNK(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );
    wide_add_seq #(.NCHUNK(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
        .cin(cin1), .op_sub(op_sub1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1)
    );

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors sample just after the falling edge; a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        #1;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut4 unexpected output: got %h expected none", {cout, sum});
            end else begin
                e4 = exp_q.pop_front();
                chk("dut4 result", {cout, sum}, e4);
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (!rst && out_valid1 && out_ready1) begin
            if (exp_q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut1 unexpected output: got %h expected none", {cout1, sum1});
            end else begin
                e1 = exp_q1.pop_front();
                chk("dut1 result", {48'd0, cout1, sum1}, {48'd0, e1});
            end
        end
    end

    // Called at a falling edge; returns at the falling edge just after the accept edge.
    task automatic send4(input logic [63:0] va, input logic [63:0] vb, input logic vc,
                         input logic vs, input logic [64:0] exp, input bit push);
        int n;
        if (push) exp_q.push_back(exp);
        a = va; b = vb; cin = vc; op_sub = vs; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) begin checks++; errors++; $display("FAIL dut4 accept timeout: got in_ready=0 expected 1"); end
        @(negedge clk);
        in_valid = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom); op_sub = 1'($urandom);
    endtask

    task automatic send1(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                         input logic vs, input logic [16:0] exp);
        int n;
        exp_q1.push_back(exp);
        a1 = va; b1 = vb; cin1 = vc; op_sub1 = vs; in_valid1 = 1'b1;
        n = 0;
        while (!in_ready1 && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) begin checks++; errors++; $display("FAIL dut1 accept timeout: got in_ready=0 expected 1"); end
        @(negedge clk);
        in_valid1 = 1'b0;
        a1 = 16'($urandom); b1 = 16'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_q1.size() != 0) && n < 1000) begin @(negedge clk); n++; end
        @(negedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rnd_on) begin
                out_ready  = 1'($urandom_range(0, 1));
                out_ready1 = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] ra, rb;
        logic        rc, rs;
        logic [64:0] re;
        rst = 1'b1;
        in_valid = 0; a = 0; b = 0; cin = 0; op_sub = 0; out_ready = 1;
        in_valid1 = 0; a1 = 0; b1 = 0; cin1 = 0; op_sub1 = 0; out_ready1 = 1;
        repeat (2) @(negedge clk);
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset sum/cout", {cout, sum}, 0);
        chk("reset dut1 in_ready/out_valid", {in_ready1, out_valid1}, 65'b10);
        rst = 1'b0;
        @(negedge clk);

        // All-ones plus one ripples a carry through every slice.
        send4(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, {1'b1, 64'd0}, 1);
        lat = 0;
        while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
        chk("t1 latency", 65'(lat), 65'd4);

        send4(64'h1_0000, 64'd1, 0, 1, {1'b1, 64'h0000_0000_0000_FFFF}, 1);
        send4(64'd0, 64'd1, 0, 1, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF}, 1);
        send4(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1, 0, {1'b1, 64'd1}, 1);
        send4(64'd5, 64'd7, 0, 1, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE}, 1);
        send4(64'd10, 64'd3, 1, 1, {1'b1, 64'd7}, 1);
        send4(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 0, 0, {1'b0, 64'h0001_0000_0001_0000}, 1);
        drain();

        // Backpressure in DONE with a second operation waiting.
        out_ready = 1'b0;
        send4(64'd5, 64'd6, 0, 0, {1'b0, 64'd11}, 1);
        a = 64'h0000_0001_0000_0000; b = 64'h0000_0000_FFFF_FFFF; cin = 1; op_sub = 0; in_valid = 1'b1;
        exp_q.push_back({1'b0, 64'h0000_0002_0000_0000});
        lat = 0;
        while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
        for (int i = 0; i < 5; i++) begin
            chk("t4 held sum/cout", {cout, sum}, {1'b0, 64'd11});
            chk("t4 in_ready low", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4 idle after release", {in_ready, out_valid}, 65'b10);
        @(negedge clk);
        chk("t4 pending accepted", in_ready, 0);
        in_valid = 1'b0;
        drain();

        // Reset while the third slice is being added: the operation must vanish.
        send4(64'h1111_2222_3333_4444, 64'h0101_0101_0101_0101, 0, 0, 65'd0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5 out_valid in reset", out_valid, 0);
        chk("t5 sum/cout in reset", {cout, sum}, 0);
        chk("t5 in_ready in reset", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send4(64'd3, 64'd4, 0, 0, {1'b0, 64'd7}, 1);
        drain();

        // Single-slice configuration.
        send1(16'hFFFF, 16'h0001, 0, 0, {1'b1, 16'h0000});
        lat = 0;
        while (!out_valid1 && lat < 50) begin @(negedge clk); lat++; end
        chk("n1 latency", 65'(lat), 65'd1);
        send1(16'h0000, 16'h0001, 0, 1, {1'b0, 16'hFFFF});
        send1(16'h8000, 16'h8000, 1, 0, {1'b1, 16'h0001});
        send1(16'h1234, 16'h1234, 1, 1, {1'b1, 16'h0000});
        drain();

        // Random traffic with random output backpressure, both configurations.
        rnd_on = 1'b1;
        for (int i = 0; i < 150; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            rb = ($urandom_range(0, 3) == 0) ? 64'd1 : {$urandom, $urandom};
            rc = 1'($urandom); rs = 1'($urandom);
            re = rs ? ({1'b0, ra} + {1'b0, ~rb} + 65'd1) : ({1'b0, ra} + {1'b0, rb} + {64'd0, rc});
            send4(ra, rb, rc, rs, re, 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        for (int i = 0; i < 100; i++) begin
            ra = {48'd0, 16'($urandom)}; rb = {48'd0, 16'($urandom)};
            rc = 1'($urandom); rs = 1'($urandom);
            re = rs ? ({49'd0, ra[15:0]} + {49'd0, ~rb[15:0]} + 65'd1)
                    : ({49'd0, ra[15:0]} + {49'd0, rb[15:0]} + {64'd0, rc});
            send1(ra[15:0], rb[15:0], rc, rs, re[16:0]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rnd_on = 1'b0;
        @(negedge clk);
        out_ready = 1'b1; out_ready1 = 1'b1;
        drain();
        chk("dut4 scoreboard empty", 65'(exp_q.size()), 65'd0);
        chk("dut1 scoreboard empty", 65'(exp_q1.size()), 65'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
